micro_sequencer: RTL and testbench

Next-state logic and state register of the microprogrammed control unit. Each cycle it takes the next-state fields (selector, target, condition select, invert) that the control-signal ROM decodes from the current state, plus the instruction opcode/funct and status inputs, and registers the 7-bit state that addresses that ROM. It supports sequential stepping, jumps, conditional branches, instruction dispatch, and memory wait loops with a timeout watchdog.

---
 rtl/micro_sequencer.sv | 148 ++++++++++++++
 tb/tb_micro_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-state logic and state register of the microprogrammed
// control unit. Selects the next 7-bit ROM address from the fields that the
// control ROM decodes for the current state. It supports stepping, jumps,
// conditional branches, opcode dispatch, and memory wait loops guarded by a
// watchdog.
module micro_sequencer #(
    parameter int       TIMEOUT     = 16,
    parameter bit [6:0] FETCH_STATE = 7'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] n_sel,
    input  logic [6:0] cr_target,
    input  logic       cond_sel,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [6:0] state,
    output logic       mem_timeout,
    output logic       illegal_op
);

    // The hold counter must be able to count up to TIMEOUT. It is always at least 1 bit wide.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        SEL_ENC     = 3'b000,
        SEL_FETCH   = 3'b001,
        SEL_JUMP    = 3'b010,
        SEL_INC     = 3'b011,
        SEL_BRANCH  = 3'b100,
        SEL_BR_DISP = 3'b101,
        SEL_WAIT    = 3'b110,
        SEL_RSVD    = 3'b111
    } nsel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    logic [6:0]    r_state;
    logic          r_mem_timeout;
    logic          r_illegal_op;
    logic [CW-1:0] r_hold_cnt;

    logic          w_cond_true;
    logic [6:0]    w_inc;
    logic [6:0]    w_enc;
    logic          w_enc_known;
    logic          w_expire;
    logic [6:0]    w_next_state;
    logic          w_next_timeout;
    logic          w_next_illegal;
    logic [CW-1:0] w_next_hold;

    assign w_cond_true = (cond_sel ? cond : moc) ^ inv;
    assign w_inc       = r_state + 7'd1;
    // This hold would bring the counter up to TIMEOUT, so the watchdog fires instead.
    assign w_expire    = (TIMEOUT != 0) && ((int'(r_hold_cnt) + 1) == TIMEOUT);

    // Instruction dispatch encoder: opcode/funct -> first execute state.
    always_comb begin
        // NOTE: defaults are assigned before the case, so every path drives every output and no latch can be inferred.
        w_enc       = FETCH_STATE;
        w_enc_known = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    w_enc       = 7'd10;
                    w_enc_known = 1'b1;
                end
            end
            OP_ADDIU: begin w_enc = 7'd11; w_enc_known = 1'b1; end
            OP_LW:    begin w_enc = 7'd6;  w_enc_known = 1'b1; end
            OP_SW:    begin w_enc = 7'd7;  w_enc_known = 1'b1; end
            OP_BEQ:   begin w_enc = 7'd8;  w_enc_known = 1'b1; end
            OP_LUI:   begin w_enc = 7'd9;  w_enc_known = 1'b1; end
            default:  ;
        endcase
    end

    // Next-state selection, watchdog counting, and the flag pulses for the next cycle.
    always_comb begin
        w_next_state   = FETCH_STATE;
        w_next_timeout = 1'b0;
        w_next_illegal = 1'b0;
        w_next_hold    = '0;
        case (nsel_e'(n_sel))
            SEL_ENC: begin
                w_next_state   = w_enc;
                w_next_illegal = ~w_enc_known;
            end
            SEL_FETCH: w_next_state = FETCH_STATE;
            SEL_JUMP:  w_next_state = cr_target;
            SEL_INC:   w_next_state = w_inc;
            SEL_BRANCH: w_next_state = w_cond_true ? cr_target : w_inc;
            SEL_BR_DISP: begin
                if (w_cond_true) begin
                    w_next_state = cr_target;
                end else begin
                    w_next_state   = w_enc;
                    w_next_illegal = ~w_enc_known;
                end
            end
            SEL_WAIT: begin
                // A completing memory op wins over a watchdog expiry in the same cycle.
                if (w_cond_true) begin
                    w_next_state = w_inc;
                end else if (w_expire) begin
                    w_next_state   = FETCH_STATE;
                    w_next_timeout = 1'b1;
                end else begin
                    w_next_state = r_state;
                    w_next_hold  = r_hold_cnt + CW'(1);
                end
            end
            SEL_RSVD: w_next_state = FETCH_STATE;
            default:  w_next_state = FETCH_STATE;
        endcase
    end

    // State register and flag registers with a synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
        if (reset) begin
            r_state       <= FETCH_STATE;
            r_mem_timeout <= 1'b0;
            r_illegal_op  <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_next_state;
            r_mem_timeout <= w_next_timeout;
            r_illegal_op  <= w_next_illegal;
            r_hold_cnt    <= w_next_hold;
        end
    end

    assign state       = r_state;
    assign mem_timeout = r_mem_timeout;
    assign illegal_op  = r_illegal_op;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer. It applies a table of single-cycle vectors
// to an instance with the default watchdog (TIMEOUT=16). It then runs hand-written
// wait-loop and watchdog sequences, using a second instance with TIMEOUT=4.
module tb_micro_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] n_sel;
    logic [6:0] cr_target;
    logic       cond_sel, inv, moc, cond;
    logic [5:0] opcode, funct;

    logic [6:0] state_a, state_b;
    logic       to_a, to_b, ill_a, ill_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    micro_sequencer #(.TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .n_sel(n_sel), .cr_target(cr_target),
        .cond_sel(cond_sel), .inv(inv), .moc(moc), .cond(cond),
        .opcode(opcode), .funct(funct),
        .state(state_a), .mem_timeout(to_a), .illegal_op(ill_a)
    );

    micro_sequencer #(.TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset), .n_sel(n_sel), .cr_target(cr_target),
        .cond_sel(cond_sel), .inv(inv), .moc(moc), .cond(cond),
        .opcode(opcode), .funct(funct),
        .state(state_b), .mem_timeout(to_b), .illegal_op(ill_b)
    );

    typedef struct packed {
        logic       rst;
        logic [2:0] nsel;
        logic [6:0] tgt;
        logic       csel;
        logic       inv;
        logic       moc;
        logic       cond;
        logic [5:0] op;
        logic [5:0] fn;
        logic [6:0] e_state;
        logic       e_to;
        logic       e_ill;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [2:0] ns, input logic [6:0] t,
                                input logic cs, input logic iv, input logic mc, input logic cd,
                                input logic [5:0] o, input logic [5:0] f,
                                input logic [6:0] es, input logic et, input logic ei);
        vec_t v;
        v.rst = r; v.nsel = ns; v.tgt = t; v.csel = cs; v.inv = iv; v.moc = mc; v.cond = cd;
        v.op = o; v.fn = f; v.e_state = es; v.e_to = et; v.e_ill = ei;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] ns, input logic [6:0] t,
                         input logic cs, input logic iv, input logic mc, input logic cd,
                         input logic [5:0] o, input logic [5:0] f);
        reset = r; n_sel = ns; cr_target = t; cond_sel = cs; inv = iv; moc = mc; cond = cd;
        opcode = o; funct = f;
    endtask

    // Apply the inputs for one cycle, then sample the outputs 1 ns after the edge.
    task automatic cycle(input logic r, input logic [2:0] ns, input logic [6:0] t,
                         input logic cs, input logic iv, input logic mc, input logic cd,
                         input logic [5:0] o, input logic [5:0] f);
        drive(r, ns, t, cs, iv, mc, cd, o, f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rst ns      tgt  cs iv mc cd op     fn     state to ill
        vecs[0]  = mk(1, 3'b010, 55, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[1]  = mk(1, 3'b010, 55, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[2]  = mk(1, 3'b011,  0, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[3]  = mk(0, 3'b011,  0, 0, 0, 0, 0, 6'h00, 6'h00,   1, 0, 0);
        vecs[4]  = mk(0, 3'b011,  0, 0, 0, 0, 0, 6'h00, 6'h00,   2, 0, 0);
        vecs[5]  = mk(0, 3'b011,  0, 0, 0, 0, 0, 6'h00, 6'h00,   3, 0, 0);
        vecs[6]  = mk(0, 3'b010, 127, 0, 0, 0, 0, 6'h00, 6'h00, 127, 0, 0);
        vecs[7]  = mk(0, 3'b011,  0, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[8]  = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h23, 6'h00,   6, 0, 0);
        vecs[9]  = mk(0, 3'b001, 99, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[10] = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h00, 6'h21,  10, 0, 0);
        vecs[11] = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h3F, 6'h00,   0, 0, 1);
        vecs[12] = mk(0, 3'b001,  0, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[13] = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h09, 6'h00,  11, 0, 0);
        vecs[14] = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h2B, 6'h00,   7, 0, 0);
        vecs[15] = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h04, 6'h00,   8, 0, 0);
        vecs[16] = mk(0, 3'b100, 40, 1, 0, 0, 1, 6'h00, 6'h00,  40, 0, 0);
        vecs[17] = mk(0, 3'b010,  8, 0, 0, 0, 0, 6'h00, 6'h00,   8, 0, 0);
        vecs[18] = mk(0, 3'b100, 40, 1, 1, 0, 1, 6'h00, 6'h00,   9, 0, 0);
        vecs[19] = mk(0, 3'b101, 50, 1, 0, 0, 0, 6'h0F, 6'h00,   9, 0, 0);
        vecs[20] = mk(0, 3'b101, 50, 1, 0, 0, 1, 6'h3F, 6'h00,  50, 0, 0);
        vecs[21] = mk(0, 3'b101, 50, 1, 0, 0, 0, 6'h3F, 6'h00,   0, 0, 1);
        vecs[22] = mk(0, 3'b010, 20, 0, 0, 0, 0, 6'h00, 6'h00,  20, 0, 0);
        vecs[23] = mk(0, 3'b111, 77, 0, 0, 0, 0, 6'h00, 6'h00,   0, 0, 0);
        vecs[24] = mk(0, 3'b000,  0, 0, 0, 0, 0, 6'h00, 6'h20,   0, 0, 1);
        vecs[25] = mk(0, 3'b100, 33, 0, 1, 0, 0, 6'h00, 6'h00,  33, 0, 0);
        vecs[26] = mk(0, 3'b100, 60, 0, 1, 1, 0, 6'h00, 6'h00,  34, 0, 0);

        drive(1, 3'b010, 55, 0, 0, 0, 0, 6'h00, 6'h00);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            vec_t v;
            v = vecs[i];
            cycle(v.rst, v.nsel, v.tgt, v.csel, v.inv, v.moc, v.cond, v.op, v.fn);
            check($sformatf("vec%0d state", i), int'(state_a), int'(v.e_state));
            check($sformatf("vec%0d mem_timeout", i), int'(to_a), int'(v.e_to));
            check($sformatf("vec%0d illegal_op", i), int'(ill_a), int'(v.e_ill));
        end

        // Wait loop on dut_a (TIMEOUT=16): five holds at state 6, then moc releases to 7.
        cycle(1, 3'b001, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 6'h23, 6'h00);
        check("wait enter state", int'(state_a), 6);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
            check($sformatf("wait hold%0d state", i), int'(state_a), 6);
            check($sformatf("wait hold%0d mem_timeout", i), int'(to_a), 0);
        end
        cycle(0, 3'b110, 0, 0, 0, 1, 0, 6'h00, 6'h00);
        check("wait release state", int'(state_a), 7);
        check("wait release mem_timeout", int'(to_a), 0);

        // Watchdog on dut_b (TIMEOUT=4): three holds, then forced return with a pulse.
        cycle(1, 3'b001, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        check("wd reset state", int'(state_b), 0);
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 6'h23, 6'h00);
        check("wd enter state", int'(state_b), 6);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
            check($sformatf("wd hold%0d state", i), int'(state_b), 6);
            check($sformatf("wd hold%0d mem_timeout", i), int'(to_b), 0);
        end
        cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        check("wd expire state", int'(state_b), 0);
        check("wd expire mem_timeout", int'(to_b), 1);
        cycle(0, 3'b001, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        check("wd pulse end mem_timeout", int'(to_b), 0);

        // The same loop with moc arriving on the expiry cycle: the release wins.
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 6'h23, 6'h00);
        check("wd2 enter state", int'(state_b), 6);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
            check($sformatf("wd2 hold%0d state", i), int'(state_b), 6);
        end
        cycle(0, 3'b110, 0, 0, 0, 1, 0, 6'h00, 6'h00);
        check("wd2 moc wins state", int'(state_b), 7);
        check("wd2 moc wins mem_timeout", int'(to_b), 0);

        // A reset in the middle of the loop abandons it without a timeout pulse.
        cycle(0, 3'b000, 0, 0, 0, 0, 0, 6'h23, 6'h00);
        cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        cycle(0, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        check("wd3 held state", int'(state_b), 6);
        cycle(1, 3'b110, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        check("wd3 reset state", int'(state_b), 0);
        check("wd3 reset mem_timeout", int'(to_b), 0);
        cycle(0, 3'b011, 0, 0, 0, 0, 0, 6'h00, 6'h00);
        check("wd3 after reset mem_timeout", int'(to_b), 0);
        check("wd3 after reset state", int'(state_b), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
